// File: rtl/usb_stuff_nrzi_tx.sv
// USB full-speed bit stuffer, NRZI encoder and line driver with elastic bit FIFO.
// Optional STUFF_COUNT_EN builds the per-packet stuffed-bit counter.
module usb_stuff_nrzi_tx #(
    parameter int DEPTH     = 32,
    parameter int START_LVL = 2
) (
    input  logic       clk,
    input  logic       rst_b,
    input  logic       bit_in,
    input  logic       bit_valid,
    input  logic       eop_req,
    output logic       dp,
    output logic       dm,
    output logic       tx_active,
    output logic       tx_done,
    output logic       underrun,
    output logic       overflow,
    output logic [7:0] stuff_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {
        IDLE, SEND, STUFF, EOP1, EOP2, EOPJ
    } state_e;

    state_e         state_q, state_d;
    logic [DEPTH-1:0] mem_q;
    logic [AW-1:0]  wr_q, rd_q;
    logic [CW-1:0]  count_q, count_d;
    logic [2:0]     ones_q, ones_d;
    logic           lvl_q, lvl_d;
    logic           pend_q, pend_d;
    logic           eop_prev_q;
    logic           dp_d, dm_d, act_d, done_d, ur_d, ovf_d;
    logic           pop, wr, rd_bit, full, empty, start;
    logic           clr_pend, clr_cnt, inc_cnt;

    assign full   = (count_q == CW'(DEPTH));
    assign empty  = (count_q == '0);
    assign rd_bit = mem_q[rd_q];
    // A simultaneous pop frees a slot, so a write at full is still accepted
    assign wr     = bit_valid && (!full || pop);
    assign ovf_d  = bit_valid && !wr;
    assign start  = (count_q >= CW'(START_LVL)) || (!empty && pend_q);
    assign count_d = count_q + CW'(wr) - CW'(pop);
    assign pend_d = (eop_req && !eop_prev_q) ? 1'b1 :
                    clr_pend                 ? 1'b0 : pend_q;

    always_comb begin
        state_d  = state_q;
        pop      = 1'b0;
        lvl_d    = lvl_q;
        ones_d   = ones_q;
        dp_d     = 1'b1;
        dm_d     = 1'b0;
        act_d    = 1'b0;
        done_d   = 1'b0;
        ur_d     = 1'b0;
        clr_pend = 1'b0;
        clr_cnt  = 1'b0;
        inc_cnt  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SEND;
                    ones_d  = '0;
                    clr_cnt = 1'b1;
                end
            end
            SEND: begin
                act_d = 1'b1;
                if (!empty) begin
                    pop    = 1'b1;
                    lvl_d  = rd_bit ? lvl_q : ~lvl_q;
                    dp_d   = lvl_d;
                    dm_d   = ~lvl_d;
                    ones_d = rd_bit ? 3'(ones_q + 3'd1) : 3'd0;
                    if (rd_bit && ones_q == 3'd5)
                        state_d = STUFF;
                end else begin
                    // Empty FIFO ends the packet; without eop it is an abort
                    dp_d    = 1'b0;
                    ur_d    = !pend_q;
                    state_d = EOP1;
                end
            end
            STUFF: begin
                act_d   = 1'b1;
                lvl_d   = ~lvl_q;
                dp_d    = lvl_d;
                dm_d    = ~lvl_d;
                ones_d  = '0;
                inc_cnt = 1'b1;
                state_d = SEND;
            end
            EOP1: begin
                act_d   = 1'b1;
                dp_d    = 1'b0;
                state_d = EOP2;
            end
            EOP2: begin
                act_d   = 1'b1;
                done_d  = 1'b1;
                state_d = EOPJ;
            end
            EOPJ: begin
                clr_pend = 1'b1;
                lvl_d    = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q    <= IDLE;
            mem_q      <= '0;
            wr_q       <= '0;
            rd_q       <= '0;
            count_q    <= '0;
            ones_q     <= '0;
            lvl_q      <= 1'b1;
            pend_q     <= 1'b0;
            eop_prev_q <= 1'b0;
            dp         <= 1'b1;
            dm         <= 1'b0;
            tx_active  <= 1'b0;
            tx_done    <= 1'b0;
            underrun   <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            state_q    <= state_d;
            if (wr) begin
                mem_q[wr_q] <= bit_in;
                wr_q        <= wr_q + 1'b1;
            end
            if (pop)
                rd_q <= rd_q + 1'b1;
            count_q    <= count_d;
            ones_q     <= ones_d;
            lvl_q      <= lvl_d;
            pend_q     <= pend_d;
            eop_prev_q <= eop_req;
            dp         <= dp_d;
            dm         <= dm_d;
            tx_active  <= act_d;
            tx_done    <= done_d;
            underrun   <= ur_d;
            overflow   <= ovf_d;
        end
    end

`ifdef STUFF_COUNT_EN
    logic [7:0] scnt_q;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b)
            scnt_q <= '0;
        else if (clr_cnt)
            scnt_q <= '0;
        else if (inc_cnt && scnt_q != 8'hFF)
            scnt_q <= scnt_q + 8'd1;
    end

    assign stuff_cnt = scnt_q;
`else
    logic unused_cnt;

    assign unused_cnt = clr_cnt ^ inc_cnt;
    assign stuff_cnt  = '0;
`endif

endmodule

// File: tb/tb_usb_stuff_nrzi_tx.sv
// Directed table-driven bench for usb_stuff_nrzi_tx.
// Line symbols: J, K, 0 (SE0); expected strings are hand-derived.
module tb_usb_stuff_nrzi_tx;
    logic       clk = 1'b0;
    logic       rst_b = 1'b1;
    logic       bit_in = 1'b0;
    logic       bit_valid = 1'b0;
    logic       eop_req = 1'b0;
    logic       dp, dm, tx_active, tx_done, underrun, overflow;
    logic [7:0] stuff_cnt;

    int n_chk = 0;
    int n_fail = 0;

    usb_stuff_nrzi_tx #(.DEPTH(32), .START_LVL(2)) dut (
        .clk(clk), .rst_b(rst_b), .bit_in(bit_in),
        .bit_valid(bit_valid), .eop_req(eop_req),
        .dp(dp), .dm(dm), .tx_active(tx_active),
        .tx_done(tx_done), .underrun(underrun),
        .overflow(overflow), .stuff_cnt(stuff_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] bits;
        int          n;
        logic        eop;
        string       line;
        int          stuffs;
        int          urs;
    } vec_t;

    vec_t vt[6];

    function automatic int exp_sc(input int s);
`ifdef STUFF_COUNT_EN
        return s;
`else
        return 0;
`endif
    endfunction

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    function automatic string sym();
        if (dp === 1'b1 && dm === 1'b0) return "J";
        if (dp === 1'b0 && dm === 1'b1) return "K";
        if (dp === 1'b0 && dm === 1'b0) return "0";
        return "X";
    endfunction

    task automatic run_vec(input string nm, input vec_t v);
        string got;
        int lat, dn, ur, ov;
        logic done_last;
        got = "";
        lat = 0; dn = 0; ur = 0; ov = 0;
        done_last = 1'b0;
        fork
            begin
                for (int i = 0; i < v.n; i++) begin
                    @(negedge clk);
                    bit_valid = 1'b1;
                    bit_in    = v.bits[v.n-1-i];
                end
                @(negedge clk);
                bit_valid = 1'b0;
                bit_in    = 1'b0;
                eop_req   = v.eop;
            end
            begin
                @(negedge clk);
                for (int k = 1; k <= 20 && lat == 0; k++) begin
                    @(negedge clk);
                    if (tx_active === 1'b1) lat = k;
                end
                for (int k = 0; k < 200 && tx_active === 1'b1; k++) begin
                    got = {got, sym()};
                    dn += int'(tx_done);
                    ur += int'(underrun);
                    ov += int'(overflow);
                    done_last = tx_done;
                    @(negedge clk);
                end
                dn += int'(tx_done);
            end
        join
        chk({nm, " latency"}, lat, 4);
        n_chk++;
        if (got != v.line) begin
            n_fail++;
            $display("FAIL %s line: got %s expected %s", nm, got, v.line);
        end
        chk({nm, " done_cnt"}, dn, 1);
        chk({nm, " done_last"}, {31'd0, done_last}, 1);
        chk({nm, " underrun"}, ur, v.urs);
        chk({nm, " overflow"}, ov, 0);
        chk({nm, " stuff_cnt"}, {24'd0, stuff_cnt}, exp_sc(v.stuffs));
        eop_req = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{64'h01, 8, 1'b1, "KJKJKJKK00J", 0, 0};
        vt[1] = '{64'hFE, 8, 1'b1, "JJJJJJKKJ00J", 1, 0};
        vt[2] = '{64'h3F, 8, 1'b1, "KJJJJJJJK00J", 1, 0};
        vt[3] = '{64'h6C, 8, 1'b1, "KKKJJJKJ00J", 0, 0};
        vt[4] = '{64'hFFFF_FFFF_FFFF, 48, 1'b1,
                  {"JJJJJJKKKKKKKJ", "JJJJJJKKKKKKKJ",
                   "JJJJJJKKKKKKKJ", "JJJJJJKKKKKKKJ", "00J"}, 8, 0};
        vt[5] = '{64'h2AA, 10, 1'b0, "JKKJJKKJJK00J", 0, 1};

        #1 rst_b = 1'b0;
        #3;
        chk("rst dp", {31'd0, dp}, 1);
        chk("rst dm", {31'd0, dm}, 0);
        chk("rst tx_active", {31'd0, tx_active}, 0);
        chk("rst tx_done", {31'd0, tx_done}, 0);
        chk("rst underrun", {31'd0, underrun}, 0);
        chk("rst overflow", {31'd0, overflow}, 0);
        chk("rst stuff_cnt", {24'd0, stuff_cnt}, 0);
        repeat (3) @(negedge clk);
        rst_b = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 6; i++)
            run_vec($sformatf("vec%0d", i), vt[i]);

        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            bit_valid = 1'b1;
            bit_in    = 1'b1;
        end
        chk("mid active", {31'd0, tx_active}, 1);
        chk("mid stuff_cnt", {24'd0, stuff_cnt}, exp_sc(1));
        #2 rst_b = 1'b0;
        #1;
        chk("mid rst dp", {31'd0, dp}, 1);
        chk("mid rst dm", {31'd0, dm}, 0);
        chk("mid rst active", {31'd0, tx_active}, 0);
        chk("mid rst done", {31'd0, tx_done}, 0);
        chk("mid rst underrun", {31'd0, underrun}, 0);
        chk("mid rst stuff_cnt", {24'd0, stuff_cnt}, 0);
        bit_valid = 1'b0;
        bit_in    = 1'b0;
        @(negedge clk);
        rst_b = 1'b1;
        repeat (3) @(negedge clk);
        chk("post rst idle", {31'd0, tx_active}, 0);
        chk("post rst J", {30'd0, dp, dm}, 2);
        run_vec("after_rst", vt[0]);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
